alu_issue_seq: RTL and testbench

- Issue/writeback sequencer that sits directly upstream and downstream of the 16-bit ALU.
- Accepts one 16-bit instruction word per handshake and reads operands from an internal 8x16 register file.
- Drives the ALU opcode and operands, waits one clock for the registered ALU result, then writes back to rd and updates the architectural S/C/Z flags.
- Non-pipelined: exactly one instruction is in flight at a time.

---
 rtl/alu_issue_seq_pkg.sv | 55 +++++
 rtl/alu_issue_seq_if.sv | 26 ++
 rtl/alu_issue_seq_regfile.sv | 43 ++++
 rtl/alu_issue_seq.sv | 134 +++++++++++++
 tb/tb_alu_issue_seq.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_issue_seq_pkg.sv
// Shared definitions for the ALU issue/writeback sequencer: widths, ALU opcodes,
// instruction field positions, FSM encoding and opcode classification helpers.
package alu_issue_seq_pkg;

  localparam int DW    = 16;
  localparam int NREGS = 8;
  localparam int AW    = $clog2(NREGS);
  localparam int OPW   = 5;

  // Opcode set shared with the downstream ALU
  localparam logic [OPW-1:0] OP_ADD = 5'h00;
  localparam logic [OPW-1:0] OP_ADC = 5'h01;
  localparam logic [OPW-1:0] OP_SUB = 5'h02;
  localparam logic [OPW-1:0] OP_INC = 5'h03;
  localparam logic [OPW-1:0] OP_DEC = 5'h04;
  localparam logic [OPW-1:0] OP_AND = 5'h05;
  localparam logic [OPW-1:0] OP_OR  = 5'h06;
  localparam logic [OPW-1:0] OP_XOR = 5'h07;
  localparam logic [OPW-1:0] OP_NOT = 5'h08;

  // Instruction word: [15:11] opcode, [10:8] rd, [7:5] ra, [4:2] rb, [1:0] reserved
  localparam int OPC_LSB = 11;
  localparam int RD_LSB  = 8;
  localparam int RA_LSB  = 5;
  localparam int RB_LSB  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  typedef struct packed {
    logic [OPW-1:0] opcode;
    logic [AW-1:0]  rd;
    logic [AW-1:0]  ra;
    logic [AW-1:0]  rb;
  } instr_t;

  function automatic logic is_legal(input logic [OPW-1:0] op);
    return op inside {OP_ADD, OP_ADC, OP_SUB, OP_INC, OP_DEC,
                      OP_AND, OP_OR, OP_XOR, OP_NOT};
  endfunction

  // Arithmetic ops report carry/borrow; logic ops leave flag_c alone
  function automatic logic sets_carry(input logic [OPW-1:0] op);
    return op inside {OP_ADD, OP_ADC, OP_SUB, OP_INC, OP_DEC};
  endfunction

  function automatic logic is_unary(input logic [OPW-1:0] op);
    return op inside {OP_INC, OP_DEC, OP_NOT};
  endfunction

endpackage

// File: rtl/alu_issue_seq_if.sv
// Instruction handshake plus ALU operand/result bus for alu_issue_seq.
// The sequencer uses the slave modport; upstream/ALU environment uses master.
interface alu_issue_seq_if;
  import alu_issue_seq_pkg::*;

  logic                instr_valid;
  logic                instr_ready;
  logic [15:0]         instr;
  logic                alu_enable;
  logic [OPW-1:0]      alu_opcode;
  logic [DW-1:0]       alu_a;
  logic [DW-1:0]       alu_b;
  logic [DW-1:0]       alu_result;
  logic                alu_carry;

  modport master (
    output instr_valid, instr, alu_result, alu_carry,
    input  instr_ready, alu_enable, alu_opcode, alu_a, alu_b
  );

  modport slave (
    input  instr_valid, instr, alu_result, alu_carry,
    output instr_ready, alu_enable, alu_opcode, alu_a, alu_b
  );

endinterface

// File: rtl/alu_issue_seq_regfile.sv
// 8x16 architectural register file: two async read ports, one sync write port.
// ALU_ISSUE_DBG_EN adds a third async read port for debug observation.
module alu_issue_regfile #(
  parameter int NREGS = 8,
  parameter int DW    = 16,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] ra_addr,
  output logic [DW-1:0] ra_data,
  input  logic [AW-1:0] rb_addr,
  output logic [DW-1:0] rb_data,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd
`ifdef ALU_ISSUE_DBG_EN
  ,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
`endif
);

  logic [DW-1:0] mem [NREGS];

  // NOTE: the array sits in flops, not a RAM macro, so it can take an async
  // reset; every entry must read 0 straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wa] <= wd;
    end
  end

  assign ra_data = mem[ra_addr];
  assign rb_data = mem[rb_addr];

`ifdef ALU_ISSUE_DBG_EN
  assign dbg_data = mem[dbg_addr];
`endif

endmodule

// File: rtl/alu_issue_seq.sv
// Non-pipelined issue/writeback sequencer around a registered 16-bit ALU.
// Optional debug read port and retired-instruction counter under ALU_ISSUE_DBG_EN.
module alu_issue_seq
  import alu_issue_seq_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  alu_issue_seq_if.slave bus,
  output logic          done,
  output logic          illegal,
  output logic          flag_s,
  output logic          flag_c,
  output logic          flag_z
`ifdef ALU_ISSUE_DBG_EN
  ,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_rdata,
  output logic [15:0]   instr_count
`endif
);

  state_e         state_q, state_d;
  instr_t         instr_q;
  logic [OPW-1:0] opcode_q;
  logic [DW-1:0]  a_q, b_q;
  logic [DW-1:0]  ra_data, rb_data;
  logic           ready, alu_en;
  logic           accept, wb_write;

  assign accept   = bus.instr_valid && ready;
  assign wb_write = (state_q == ST_WB) && is_legal(instr_q.opcode);

  alu_issue_regfile #(.NREGS(NREGS), .DW(DW)) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .ra_addr (instr_q.ra),
    .ra_data (ra_data),
    .rb_addr (instr_q.rb),
    .rb_data (rb_data),
    .we      (wb_write),
    .wa      (instr_q.rd),
    .wd      (bus.alu_result)
`ifdef ALU_ISSUE_DBG_EN
    ,
    .dbg_addr(dbg_addr),
    .dbg_data(dbg_rdata)
`endif
  );

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    alu_en  = 1'b0;
    done    = 1'b0;
    illegal = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        if (bus.instr_valid) state_d = ST_READ;
      end
      ST_READ: state_d = ST_EXEC;
      ST_EXEC: begin
        alu_en  = 1'b1;
        state_d = ST_WB;
      end
      ST_WB: begin
        done    = 1'b1;
        illegal = !is_legal(instr_q.opcode);
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Fields are captured only on acceptance; instr is ignored while busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= '0;
    end else if (accept) begin
      instr_q.opcode <= bus.instr[OPC_LSB +: OPW];
      instr_q.rd     <= bus.instr[RD_LSB  +: AW];
      instr_q.ra     <= bus.instr[RA_LSB  +: AW];
      instr_q.rb     <= bus.instr[RB_LSB  +: AW];
    end
  end

  // Operands are read before writeback, so rd==ra/rb sees the old value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
    end else if (state_q == ST_READ) begin
      opcode_q <= instr_q.opcode;
      a_q      <= ra_data;
      b_q      <= is_unary(instr_q.opcode) ? '0 : rb_data;
    end
  end

  // S and Z come from the result itself; C only from arithmetic ops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_s <= 1'b0;
      flag_c <= 1'b0;
      flag_z <= 1'b0;
    end else if (wb_write) begin
      flag_z <= (bus.alu_result == '0);
      flag_s <= bus.alu_result[DW-1];
      if (sets_carry(instr_q.opcode)) flag_c <= bus.alu_carry;
    end
  end

  assign bus.instr_ready = ready;
  assign bus.alu_enable  = alu_en;
  assign bus.alu_opcode  = opcode_q;
  assign bus.alu_a       = a_q;
  assign bus.alu_b       = b_q;

`ifdef ALU_ISSUE_DBG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    instr_count <= '0;
    else if (done) instr_count <= instr_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_alu_issue_seq.sv
// Self-checking bench for alu_issue_seq: behavioural ALU, architectural reference
// model, directed scenarios then randomized instructions. Honours ALU_ISSUE_DBG_EN.
module tb_alu_issue_seq;
  import alu_issue_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_issue_seq_if bus ();
  logic done, illegal, flag_s, flag_c, flag_z;
`ifdef ALU_ISSUE_DBG_EN
  logic [2:0]  dbg_addr = 3'd0;
  logic [15:0] dbg_rdata, instr_count;
`endif

  alu_issue_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .done    (done),
    .illegal (illegal),
    .flag_s  (flag_s),
    .flag_c  (flag_c),
    .flag_z  (flag_z)
`ifdef ALU_ISSUE_DBG_EN
    ,
    .dbg_addr    (dbg_addr),
    .dbg_rdata   (dbg_rdata),
    .instr_count (instr_count)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Result/carry of the ALU as a 17-bit {carry, result}; logic ops pass cin through
  function automatic logic [16:0] spec_alu(input logic [4:0] op, input logic [15:0] a,
                                           input logic [15:0] b, input logic cin);
    case (op)
      OP_ADD:  return {1'b0, a} + {1'b0, b};
      OP_ADC:  return {1'b0, a} + {1'b0, b} + {16'h0, cin};
      OP_SUB:  return {a < b, a - b};
      OP_INC:  return {1'b0, a} + 17'd1;
      OP_DEC:  return {a == 16'h0, a - 16'd1};
      OP_AND:  return {cin, a & b};
      OP_OR:   return {cin, a | b};
      OP_XOR:  return {cin, a ^ b};
      OP_NOT:  return {cin, ~a};
      default: return {cin, 16'h0};
    endcase
  endfunction

  // Behavioural registered ALU; ovr_en forces a result to preload registers
  logic        ovr_en = 1'b0;
  logic [15:0] ovr_val = 16'h0;
  logic        alu_c_q;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.alu_result <= 16'h0;
      alu_c_q        <= 1'b0;
    end else if (bus.alu_enable) begin
      if (ovr_en) bus.alu_result <= ovr_val;
      else {alu_c_q, bus.alu_result} <= spec_alu(bus.alu_opcode, bus.alu_a, bus.alu_b, alu_c_q);
    end
  end
  assign bus.alu_carry = alu_c_q;

  // Architectural reference model
  logic [15:0] m_reg [8];
  logic        m_s, m_c, m_z;
  int          m_done;
  logic [15:0] last_a;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = 16'h0;
    m_s = 1'b0; m_c = 1'b0; m_z = 1'b0; m_done = 0;
  endtask

  function automatic bit legal_op(input logic [4:0] op);
    return op <= OP_NOT;
  endfunction

  task automatic model_exec(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] ra,
                            input logic [2:0] rb, input bit forced, input logic [15:0] fval);
    logic [16:0] r;
    m_done++;
    if (!legal_op(op)) return;
    r = forced ? {m_c, fval} : spec_alu(op, m_reg[ra], m_reg[rb], m_c);
    m_reg[rd] = r[15:0];
    m_z = (r[15:0] == 16'h0);
    m_s = r[15];
    if (op inside {OP_ADD, OP_ADC, OP_SUB, OP_INC, OP_DEC}) m_c = r[16];
  endtask

  // Issue one instruction and check handshake, operands, latency, pulses, flags
  task automatic run_instr(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] ra,
                           input logic [2:0] rb, input bit forced, input logic [15:0] fval);
    logic [15:0] exp_a, exp_b;
    int n;
    exp_a = m_reg[ra];
    exp_b = (op inside {OP_INC, OP_DEC, OP_NOT}) ? 16'h0 : m_reg[rb];
    ovr_en = forced; ovr_val = fval;
    @(negedge clk);
    n = 0;
    while (!bus.instr_ready && n < 20) begin @(negedge clk); n++; end
    check("ready_before_issue", {31'h0, bus.instr_ready}, 32'h1);
    bus.instr = {op, rd, ra, rb, 2'($urandom)};
    bus.instr_valid = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    bus.instr = 16'($urandom);
    check("ready_low_in_read", {31'h0, bus.instr_ready}, 32'h0);
    @(negedge clk);
    n = 2;
    check("alu_enable_exec", {31'h0, bus.alu_enable}, 32'h1);
    check("alu_opcode", {27'h0, bus.alu_opcode}, {27'h0, op});
    check("alu_a", {16'h0, bus.alu_a}, {16'h0, exp_a});
    check("alu_b", {16'h0, bus.alu_b}, {16'h0, exp_b});
    last_a = bus.alu_a;
    do begin @(negedge clk); n++; end while (!done && n < 10);
    check("done_latency", n, 3);
    check("illegal_pulse", {31'h0, illegal}, {31'h0, !legal_op(op)});
    model_exec(op, rd, ra, rb, forced, fval);
    @(negedge clk);
    check("done_one_cycle", {31'h0, done}, 32'h0);
    check("ready_after_wb", {31'h0, bus.instr_ready}, 32'h1);
    check("flags_szc", {29'h0, flag_s, flag_z, flag_c}, {29'h0, m_s, m_z, m_c});
    ovr_en = 1'b0;
  endtask

  task automatic preload(input logic [2:0] r, input logic [15:0] v);
    run_instr(OP_OR, r, 3'd0, 3'd0, 1'b1, v);
  endtask

  // An illegal opcode changes nothing, so it serves as a register read probe
  task automatic probe(input string tag, input logic [2:0] r, input logic [15:0] exp);
    run_instr(5'h1F, 3'd0, r, r, 1'b0, 16'h0);
    check(tag, {16'h0, last_a}, {16'h0, exp});
  endtask

  logic [4:0] legal_list [9] = '{OP_ADD, OP_ADC, OP_SUB, OP_INC, OP_DEC,
                                 OP_AND, OP_OR, OP_XOR, OP_NOT};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc [$];
    int na, n;
    bit done_seen;
    logic [2:0] saved_flags;
    logic [4:0] op;

    bus.instr_valid = 1'b0;
    bus.instr = 16'h0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset then idle
    @(negedge clk);
    check("rst_ready", {31'h0, bus.instr_ready}, 32'h1);
    check("rst_flags", {29'h0, flag_s, flag_c, flag_z}, 32'h0);
    check("rst_alu_bus", {bus.alu_enable, bus.alu_opcode, bus.alu_a[7:0], bus.alu_b[7:0]}, 32'h0);
    done_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || illegal) done_seen = 1'b1;
    end
    check("idle_no_done", {31'h0, done_seen}, 32'h0);

    // ADD with wrap
    preload(3'd1, 16'hFFFF);
    preload(3'd2, 16'h0001);
    run_instr(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0);
    check("add_wrap_flags", {29'h0, flag_s, flag_z, flag_c}, {29'h0, 3'b011});
    probe("add_wrap_r3", 3'd3, 16'h0000);

    // SUB negative
    preload(3'd1, 16'h0002);
    preload(3'd2, 16'h0005);
    run_instr(OP_SUB, 3'd4, 3'd1, 3'd2, 1'b0, 16'h0);
    check("sub_neg_sz", {30'h0, flag_s, flag_z}, {30'h0, 2'b10});
    probe("sub_neg_r4", 3'd4, 16'hFFFD);

    // AND after a carry leaves flag_c set
    preload(3'd1, 16'hFFFF);
    preload(3'd2, 16'h0001);
    run_instr(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0);
    preload(3'd1, 16'h0F0F);
    preload(3'd2, 16'h00FF);
    run_instr(OP_AND, 3'd5, 3'd1, 3'd2, 1'b0, 16'h0);
    check("and_keeps_c", {30'h0, flag_c, flag_z}, {30'h0, 2'b10});
    probe("and_r5", 3'd5, 16'h000F);

    // Illegal opcode: no write, no flag change
    saved_flags = {flag_s, flag_c, flag_z};
    run_instr(5'h15, 3'd5, 3'd1, 3'd2, 1'b0, 16'h0);
    check("illegal_flags_kept", {29'h0, flag_s, flag_c, flag_z}, {29'h0, saved_flags});
    probe("illegal_r5_kept", 3'd5, 16'h000F);

    // rd == ra == rb reads old value, writes new
    run_instr(OP_ADD, 3'd1, 3'd1, 3'd1, 1'b0, 16'h0);
    probe("self_add_r1", 3'd1, 16'h1E1E);

    // Back-to-back: valid held high, instr scrambled while busy
    preload(3'd6, 16'hFFFE);
    na = 0;
    bus.instr_valid = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (bus.instr_ready) begin
        if (na == 3) break;
        bus.instr = {OP_INC, 3'd6, 3'd6, 3'd0, 2'b00};
        acc.push_back(c);
        na++;
      end else begin
        bus.instr = 16'($urandom);
      end
      @(negedge clk);
    end
    bus.instr_valid = 1'b0;
    repeat (3) model_exec(OP_INC, 3'd6, 3'd6, 3'd0, 1'b0, 16'h0);
    check("busy_accepts", na, 3);
    if (acc.size() == 3) begin
      check("busy_spacing_0", acc[1] - acc[0], 4);
      check("busy_spacing_1", acc[2] - acc[1], 4);
    end
    check("busy_flags", {29'h0, flag_s, flag_z, flag_c}, 32'h0);
    probe("busy_r6", 3'd6, 16'h0001);

    // Reset during EXEC aborts the instruction
    preload(3'd1, 16'h1234);
    preload(3'd2, 16'h0001);
    @(negedge clk);
    n = 0;
    while (!bus.instr_ready && n < 20) begin @(negedge clk); n++; end
    bus.instr = {OP_ADD, 3'd7, 3'd1, 3'd2, 2'b00};
    bus.instr_valid = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_exec", {31'h0, bus.alu_enable}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", {28'h0, bus.instr_ready, bus.alu_enable, done, illegal}, 32'h8);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    check("rst_mid_ready", {31'h0, bus.instr_ready}, 32'h1);
    check("rst_mid_flags", {29'h0, flag_s, flag_c, flag_z}, 32'h0);
    probe("rst_mid_r7", 3'd7, 16'h0000);
    probe("rst_mid_r1", 3'd1, 16'h0000);

    // Randomized instruction stream against the reference model
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 6) == 0) begin
        preload(3'($urandom), 16'($urandom));
      end else begin
        if ($urandom_range(0, 4) == 0) op = 5'($urandom_range(9, 31));
        else op = legal_list[$urandom_range(0, 8)];
        run_instr(op, 3'($urandom), 3'($urandom), 3'($urandom), 1'b0, 16'h0);
      end
    end
    for (int r = 0; r < 8; r++) probe("final_reg", 3'(r), m_reg[r]);

`ifdef ALU_ISSUE_DBG_EN
    for (int r = 0; r < 8; r++) begin
      dbg_addr = 3'(r);
      #1;
      check("dbg_rdata", {16'h0, dbg_rdata}, {16'h0, m_reg[r]});
    end
    check("instr_count", {16'h0, instr_count}, {16'h0, 16'(m_done)});
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
